bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Relays 68000 bus arbitration between the Amiga motherboard (Agnus/Zorro DMA masters) and the local 68SEC000 on the accelerator.
- Sits directly upstream of the CPU bus path in main_top. It owns BR_68SEC000_n and BGACK_68SEC000_n and the motherboard BG_n pull-down.
- Emits CPU_OFF_BUS. fastram, ata and the AS_MB_n driver consume it to stop decoding and tristate while an external master owns the bus.
- Clocked from C7M, so arbitration timing is independent of the turbo CLKCPU selection.

Parameters:
- SYNC_STAGES, 2: flops per asynchronous input synchroniser (minimum 2).
- GRANT_TIMEOUT, 32: C7M cycles a relayed grant may remain unacknowledged after the request is withdrawn.
- HOLDOFF, 2: C7M cycles the CPU is held off after BGACK_n negates.

Ports:
- C7M  in  1  system clock (7.09/7.16 MHz).
- RESET  in  1  synchronous, active-high reset.
- BR_MB_n  in  1  motherboard bus request (BR_n pin, input only), asynchronous.
- BGACK_n  in  1  motherboard bus-grant acknowledge, asynchronous.
- AS_CPU_n  in  1  local CPU address strobe, asynchronous to C7M.
- AS_MB_n  in  1  motherboard address strobe as seen on the pin, asynchronous.
- BG_68SEC000_n  in  1  bus grant from local CPU, asynchronous.
- BR_68SEC000_n  out  1  bus request to local CPU.
- BGACK_68SEC000_n  out  1  bus-grant acknowledge to local CPU.
- BG_MB_DRV  out  1  when 1, top level drives BG_n low; otherwise BG_n is Z.
- CPU_OFF_BUS  out  1  1 = local CPU has released the motherboard bus.
- ARB_STATE  out  3  current state encoding, for debug.

Behaviour:
- Synchronisers:
  - Each asynchronous input passes through SYNC_STAGES flops, giving br_s, bgack_s, as_cpu_s, as_mb_s and bg_cpu_s.
  - All synchroniser flops reset to 1 (negated).
- Outputs are decoded from the state register only, with no input-to-output combinational path.
- Reset values: BR_68SEC000_n=1, BGACK_68SEC000_n=1, BG_MB_DRV=0, CPU_OFF_BUS=0, ARB_STATE=IDLE, timeout counter=0.
- Reset mid-operation: at the reset edge, all outputs return to their reset values and state returns to IDLE.
- States and encodings: IDLE=0, REQ=1, GRANT=2, DMA=3, RELEASE=4.
- IDLE:
  - All outputs negated.
  - br_s=0 and bgack_s=1 → REQ.
  - br_s=0 while bgack_s=0 → stay in IDLE (a foreign master still owns the bus).
- REQ:
  - BR_68SEC000_n=0.
  - br_s=1 → IDLE (request withdrawn before grant).
  - Otherwise bg_cpu_s=0 → GRANT.
  - Withdrawal wins over a simultaneous grant.
- GRANT:
  - BR_68SEC000_n=0, BG_MB_DRV=1.
  - CPU_OFF_BUS=as_cpu_s, registered: set once the CPU's current cycle has ended.
  - bgack_s=0 and as_cpu_s=1 → DMA.
  - While br_s=1 and bgack_s=1, the counter increments. When the counter reaches GRANT_TIMEOUT-1 → IDLE (abandoned grant).
  - The counter clears on entry to GRANT, and whenever br_s=0 or bgack_s=0.
- DMA:
  - BR_68SEC000_n=1, BG_MB_DRV=0, BGACK_68SEC000_n=0, CPU_OFF_BUS=1.
  - bgack_s=1 → RELEASE.
  - br_s activity is ignored in this state.
- RELEASE:
  - BGACK_68SEC000_n=0, CPU_OFF_BUS=1.
  - The counter counts HOLDOFF cycles.
  - When the count is done and as_mb_s=1 → IDLE.
  - If AS_MB_n is still low, hold the state indefinitely.
  - A new request arriving in this state is serviced only from IDLE, one cycle later.
- Latency (SYNC_STAGES=2): input sampled low at edge 0, synchronised after edge 1, state change and output at edge 2.
  - BR_MB_n falling → BR_68SEC000_n falls 3 edges after it is first sampled low.
  - The same 3-edge latency applies to every input-driven transition.
- Counter: width is clog2(max(GRANT_TIMEOUT,HOLDOFF)+1). It saturates and never wraps.

Decomposition:
- Shared package sf2000_pkg:
  - arb_state_t enum (3-bit) and its state encoding constants.
  - Default constants ARB_SYNC_STAGES, ARB_GRANT_TIMEOUT, ARB_HOLDOFF.
- One sub-module sync_bit:
  - Parameterised depth, reset value 1, one instance per asynchronous input.
  - Reusable by clock and m6800.

Test Plan:
- Full DMA cycle: BR_MB_n low → BR_68SEC000_n low 3 edges later; drive BG_68SEC000_n low → BG_MB_DRV=1 after 3 edges; AS_CPU_n high and BGACK_n low → DMA with BGACK_68SEC000_n=0, BG_MB_DRV=0; BGACK_n high → RELEASE; IDLE 2 cycles after as_mb_s high.
- Withdrawal: BR_MB_n low for 4 cycles, then high before BG_68SEC000_n asserts → back to IDLE, BG_MB_DRV never 1.
- Grant timeout: reach GRANT, then BR_MB_n high with no BGACK_n → IDLE exactly 32 cycles after br_s=1, all outputs negated.
- CPU cycle in flight: GRANT with AS_CPU_n held low 10 cycles and BGACK_n low → stays in GRANT, CPU_OFF_BUS=0, until as_cpu_s=1, then DMA.
- RELEASE stall: BGACK_n high while AS_MB_n stays low 20 cycles → RELEASE held, BGACK_68SEC000_n=0 throughout; IDLE 3 edges after AS_MB_n rises.
- Reset in DMA: assert RESET one cycle → next edge all outputs at reset values, ARB_STATE=0.

Source files
------------

// File: rtl/sf2000_pkg.sv
// Shared types and defaults for the accelerator's bus-arbitration logic.
// The output decode lives here so every consumer agrees on what each state drives.
package sf2000_pkg;

  localparam int ARB_SYNC_STAGES   = 2;
  localparam int ARB_GRANT_TIMEOUT = 32;
  localparam int ARB_HOLDOFF       = 2;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_REQ     = 3'd1,
    ARB_GRANT   = 3'd2,
    ARB_DMA     = 3'd3,
    ARB_RELEASE = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic br_n;
    logic bgack_n;
    logic bg_drv;
    logic off_bus;
  } arb_out_t;

  localparam arb_out_t ARB_OUT_RESET = '{br_n: 1'b1, bgack_n: 1'b1, bg_drv: 1'b0, off_bus: 1'b0};

  // Output levels for the state about to be entered. as_cpu is the synchronised
  // CPU address strobe, used to mark the local bus free once the CPU cycle ends.
  function automatic arb_out_t arb_decode(input arb_state_t s, input logic as_cpu);
    arb_out_t o;
    o = ARB_OUT_RESET;
    case (s)
      ARB_REQ: o.br_n = 1'b0;
      ARB_GRANT: begin
        o.br_n    = 1'b0;
        o.bg_drv  = 1'b1;
        o.off_bus = as_cpu;
      end
      ARB_DMA, ARB_RELEASE: begin
        o.bgack_n = 1'b0;
        o.off_bus = 1'b1;
      end
      default: o = ARB_OUT_RESET;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous, active-low signal.
// Every stage resets to 1 so a synchronised input reads negated out of reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/bus_arbiter.sv
// Relays motherboard DMA bus requests to the local 68SEC000 and back.
// Runs on C7M; all pins are synchronised first and outputs are registered.
module bus_arbiter
  import sf2000_pkg::*;
#(
  parameter int SYNC_STAGES   = ARB_SYNC_STAGES,
  parameter int GRANT_TIMEOUT = ARB_GRANT_TIMEOUT,
  parameter int HOLDOFF       = ARB_HOLDOFF
) (
  input  logic       C7M,
  input  logic       RESET,
  input  logic       BR_MB_n,
  input  logic       BGACK_n,
  input  logic       AS_CPU_n,
  input  logic       AS_MB_n,
  input  logic       BG_68SEC000_n,
  output logic       BR_68SEC000_n,
  output logic       BGACK_68SEC000_n,
  output logic       BG_MB_DRV,
  output logic       CPU_OFF_BUS,
  output logic [2:0] ARB_STATE
);

  localparam int CNT_MAX = (GRANT_TIMEOUT > HOLDOFF) ? GRANT_TIMEOUT : HOLDOFF;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TO_LAST = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] HO_DONE = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);

  logic [4:0] raw, syn;
  logic       br_s, bgack_s, as_cpu_s, as_mb_s, bg_cpu_s;

  assign raw = {BR_MB_n, BGACK_n, AS_CPU_n, AS_MB_n, BG_68SEC000_n};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (C7M),
      .rst (RESET),
      .d   (raw[i]),
      .q   (syn[i])
    );
  end

  assign {br_s, bgack_s, as_cpu_s, as_mb_s, bg_cpu_s} = syn;

  arb_state_t      state, nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  arb_out_t        outs;

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      ARB_IDLE: begin
        cnt_nxt = '0;
        // A low BGACK_n means some other master still owns the bus.
        if (!br_s && bgack_s) nxt = ARB_REQ;
      end
      ARB_REQ: begin
        cnt_nxt = '0;
        if (br_s)           nxt = ARB_IDLE;
        else if (!bg_cpu_s) nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        if (!bgack_s && as_cpu_s) begin
          nxt     = ARB_DMA;
          cnt_nxt = '0;
        end else if (br_s && bgack_s) begin
          // Requester vanished without acknowledging: give up after the timeout.
          if (cnt >= TO_LAST) begin
            nxt     = ARB_IDLE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      ARB_DMA: begin
        cnt_nxt = '0;
        if (bgack_s) nxt = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        if (cnt >= HO_DONE) begin
          if (as_mb_s) begin
            nxt     = ARB_IDLE;
            cnt_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        nxt     = ARB_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge C7M) begin
    if (RESET) begin
      state <= ARB_IDLE;
      cnt   <= '0;
      outs  <= ARB_OUT_RESET;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      outs  <= arb_decode(nxt, as_cpu_s);
    end
  end

  assign BR_68SEC000_n    = outs.br_n;
  assign BGACK_68SEC000_n = outs.bgack_n;
  assign BG_MB_DRV        = outs.bg_drv;
  assign CPU_OFF_BUS      = outs.off_bus;
  assign ARB_STATE        = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus random pin activity, each cycle compared against a
// timestamp-based behavioural model of the arbitration rules.
module tb_bus_arbiter;

  localparam int GT = 32;
  localparam int HO = 2;

  logic C7M = 1'b0;
  logic RESET = 1'b1;
  logic BR_MB_n = 1'b1, BGACK_n = 1'b1, AS_CPU_n = 1'b1, AS_MB_n = 1'b1, BG_68SEC000_n = 1'b1;
  logic BR_68SEC000_n, BGACK_68SEC000_n, BG_MB_DRV, CPU_OFF_BUS;
  logic [2:0] ARB_STATE;

  int total = 0;
  int bad = 0;

  bus_arbiter dut (
    .C7M              (C7M),
    .RESET            (RESET),
    .BR_MB_n          (BR_MB_n),
    .BGACK_n          (BGACK_n),
    .AS_CPU_n         (AS_CPU_n),
    .AS_MB_n          (AS_MB_n),
    .BG_68SEC000_n    (BG_68SEC000_n),
    .BR_68SEC000_n    (BR_68SEC000_n),
    .BGACK_68SEC000_n (BGACK_68SEC000_n),
    .BG_MB_DRV        (BG_MB_DRV),
    .CPU_OFF_BUS      (CPU_OFF_BUS),
    .ARB_STATE        (ARB_STATE)
  );

  always #5 C7M = ~C7M;

  wire [6:0] obs = {ARB_STATE, BR_68SEC000_n, BGACK_68SEC000_n, BG_MB_DRV, CPU_OFF_BUS};
  localparam logic [6:0] RST_VEC = 7'b000_1100;

  // Reference model: two-flop delay lines, a phase number, and timestamps
  // (cycle numbers) instead of a counter for the timeout and holdoff rules.
  logic [1:0] p_br = 2'b11, p_bgack = 2'b11, p_ascpu = 2'b11, p_asmb = 2'b11, p_bg = 2'b11;
  int   ph = 0;
  int   cyc = 0;
  int   t_mark = 0;
  int   t_rel = 0;
  logic m_off = 1'b0;

  wire br_s = p_br[1], bgack_s = p_bgack[1], as_s = p_ascpu[1], asmb_s = p_asmb[1], bg_s = p_bg[1];

  always @(posedge C7M) begin
    cyc <= cyc + 1;
    if (RESET) begin
      p_br <= 2'b11; p_bgack <= 2'b11; p_ascpu <= 2'b11; p_asmb <= 2'b11; p_bg <= 2'b11;
      ph <= 0;
      m_off <= 1'b0;
    end else begin
      p_br <= {p_br[0], BR_MB_n};
      p_bgack <= {p_bgack[0], BGACK_n};
      p_ascpu <= {p_ascpu[0], AS_CPU_n};
      p_asmb <= {p_asmb[0], AS_MB_n};
      p_bg <= {p_bg[0], BG_68SEC000_n};
      m_off <= as_s;
      case (ph)
        0: if (!br_s && bgack_s) ph <= 1;
        1: if (br_s) ph <= 0;
           else if (!bg_s) begin ph <= 2; t_mark <= cyc + 1; end
        2: if (!bgack_s && as_s) ph <= 3;
           else if (br_s && bgack_s) begin
             if (cyc - t_mark + 1 >= GT) ph <= 0;
           end else t_mark <= cyc + 1;
        3: if (bgack_s) begin ph <= 4; t_rel <= cyc; end
        4: if (cyc - t_rel >= HO && asmb_s) ph <= 0;
        default: ph <= 0;
      endcase
    end
  end

  function automatic logic [6:0] expect_vec();
    logic br, bgack, drv, off;
    br    = !(ph == 1 || ph == 2);
    bgack = !(ph == 3 || ph == 4);
    drv   = (ph == 2);
    off   = (ph >= 3) || (ph == 2 && m_off);
    return {3'(ph), br, bgack, drv, off};
  endfunction

  task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge C7M);
    @(negedge C7M);
    chk("model", obs, expect_vec());
  endtask

  logic drv_seen;

  initial begin
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    chk("reset_state", obs, RST_VEC);

    // Full DMA cycle with latency checks
    BR_MB_n = 1'b0;
    repeat (2) tick();
    chk("br_lat_pre", 7'(BR_68SEC000_n), 7'd1);
    tick();
    chk("br_lat", 7'(BR_68SEC000_n), 7'd0);
    BG_68SEC000_n = 1'b0;
    repeat (2) tick();
    chk("bg_lat_pre", 7'(BG_MB_DRV), 7'd0);
    tick();
    chk("bg_lat", 7'(BG_MB_DRV), 7'd1);
    BGACK_n = 1'b0;
    repeat (3) tick();
    chk("dma_enter", obs, 7'b011_1001);
    BR_MB_n = 1'b1; BG_68SEC000_n = 1'b1; BGACK_n = 1'b1;
    repeat (3) tick();
    chk("release_enter", 7'(ARB_STATE), 7'd4);
    tick();
    chk("release_hold", 7'(ARB_STATE), 7'd4);
    tick();
    chk("release_done", obs, RST_VEC);

    // Withdrawal before grant
    drv_seen = 1'b0;
    BR_MB_n = 1'b0;
    repeat (4) begin tick(); drv_seen = drv_seen | BG_MB_DRV; end
    BR_MB_n = 1'b1;
    repeat (4) begin tick(); drv_seen = drv_seen | BG_MB_DRV; end
    chk("withdraw_state", 7'(ARB_STATE), 7'd0);
    chk("withdraw_drv", 7'(drv_seen), 7'd0);

    // Abandoned grant times out
    BR_MB_n = 1'b0; BG_68SEC000_n = 1'b0;
    repeat (6) tick();
    chk("to_grant", 7'(ARB_STATE), 7'd2);
    BR_MB_n = 1'b1; BG_68SEC000_n = 1'b1;
    repeat (33) tick();
    chk("timeout_pre", 7'(ARB_STATE), 7'd2);
    tick();
    chk("timeout_idle", obs, RST_VEC);

    // CPU cycle still in flight holds GRANT
    AS_CPU_n = 1'b0; BR_MB_n = 1'b0; BG_68SEC000_n = 1'b0;
    repeat (6) tick();
    BGACK_n = 1'b0;
    repeat (10) begin
      tick();
      chk("inflight", {ARB_STATE, 3'b000, CPU_OFF_BUS}, 7'b010_0000);
    end
    AS_CPU_n = 1'b1;
    repeat (2) tick();
    chk("inflight_end_pre", 7'(ARB_STATE), 7'd2);
    tick();
    chk("inflight_dma", 7'(ARB_STATE), 7'd3);

    // RELEASE stalls while the motherboard strobe is still low
    BR_MB_n = 1'b1; BG_68SEC000_n = 1'b1; AS_MB_n = 1'b0; BGACK_n = 1'b1;
    repeat (3) tick();
    repeat (20) begin
      tick();
      chk("stall", {ARB_STATE, 3'b000, BGACK_68SEC000_n}, 7'b100_0000);
    end
    AS_MB_n = 1'b1;
    repeat (2) tick();
    chk("stall_end_pre", 7'(ARB_STATE), 7'd4);
    tick();
    chk("stall_idle", obs, RST_VEC);

    // Reset in the middle of DMA
    BR_MB_n = 1'b0; BG_68SEC000_n = 1'b0;
    repeat (6) tick();
    BGACK_n = 1'b0;
    repeat (4) tick();
    chk("pre_reset_dma", 7'(ARB_STATE), 7'd3);
    RESET = 1'b1;
    tick();
    chk("reset_dma", obs, RST_VEC);
    RESET = 1'b0;
    // Request seen while a foreign master holds BGACK_n: stay idle
    repeat (5) tick();
    chk("foreign_idle", 7'(ARB_STATE), 7'd0);
    BR_MB_n = 1'b1; BGACK_n = 1'b1; BG_68SEC000_n = 1'b1;
    repeat (4) tick();

    // Random pin activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) BR_MB_n = ~BR_MB_n;
      if ($urandom_range(9) == 0) BGACK_n = ~BGACK_n;
      if ($urandom_range(5) == 0) AS_CPU_n = ~AS_CPU_n;
      if ($urandom_range(5) == 0) AS_MB_n = ~AS_MB_n;
      if ($urandom_range(6) == 0) BG_68SEC000_n = ~BG_68SEC000_n;
      RESET = ($urandom_range(299) == 0);
      tick();
    end
    RESET = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
